// File: rtl/if_stage_pipelined.sv
// Instruction-fetch stage: owned PC, next-PC selection with stall/redirect priority,
// word-addressed instruction store with a load port, and the IF/ID pipeline register.
module if_stage_pipelined #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   input  logic                     load_we,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [DATA_W-1:0]        load_data,
   output logic [ADDR_W-1:0]        pc,
   output logic [DATA_W-1:0]        if_id_instr,
   output logic [ADDR_W-1:0]        if_id_pc4,
   output logic                     if_id_valid,
   output logic                     fault
);

   localparam int IDX_W = $clog2(DEPTH);
   // Wide enough that the range check never truncates either ADDR_W or DEPTH
   localparam int CMP_W = ADDR_W + 32;

   logic [DATA_W-1:0] store [DEPTH];
   logic [IDX_W-1:0]  fetch_idx;
   logic              in_range;
   logic [DATA_W-1:0] fetch_word;
   logic [ADDR_W-1:0] pc_plus4;
   logic              misaligned;

   always_comb begin
      fetch_idx  = pc[IDX_W+1:2];
      in_range   = CMP_W'(pc >> 2) < CMP_W'(unsigned'(DEPTH));
      fetch_word = in_range ? store[fetch_idx] : '0;
      pc_plus4   = pc + ADDR_W'(4);
      misaligned = redirect_pc[1:0] != 2'b00;
   end

   // Load writes land at the edge, so a same-edge fetch still sees the old word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            store[i] <= '0;
         end
      end else if (load_we) begin
         store[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= RESET_PC;
         if_id_instr <= '0;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
         fault       <= 1'b0;
      end else if (redirect) begin
         pc          <= {redirect_pc[ADDR_W-1:2], 2'b00};
         if_id_instr <= '0;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
         if (misaligned) begin
            fault <= 1'b1;
         end
      end else if (!stall) begin
         pc          <= pc_plus4;
         if_id_instr <= fetch_word;
         if_id_pc4   <= pc_plus4;
         if_id_valid <= 1'b1;
         if (!in_range) begin
            fault <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_if_stage_pipelined.sv
// Directed bench for if_stage_pipelined: a default 32-bit instance plus an
// 8-bit-PC instance used for the wrap-around case.
module tb_if_stage_pipelined;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        load_we;
   logic [5:0]  load_addr;
   logic [31:0] load_data;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fault;

   logic        stall8;
   logic        redirect8;
   logic [7:0]  redirect_pc8;
   logic [7:0]  pc8;
   logic [31:0] if_id_instr8;
   logic [7:0]  if_id_pc4_8;
   logic        if_id_valid8;
   logic        fault8;

   int errorCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   if_stage_pipelined dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .pc(pc), .if_id_instr(if_id_instr),
      .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fault(fault)
   );

   if_stage_pipelined #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .RESET_PC(8'h00)) dut8 (
      .clk(clk), .reset(reset), .stall(stall8), .redirect(redirect8),
      .redirect_pc(redirect_pc8), .load_we(1'b0), .load_addr(6'd0),
      .load_data(32'd0), .pc(pc8), .if_id_instr(if_id_instr8),
      .if_id_pc4(if_id_pc4_8), .if_id_valid(if_id_valid8), .fault(fault8)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIfId(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid, input logic [31:0] pcExp);
      checkOutput({tag, ".instr"}, if_id_instr, instr);
      checkOutput({tag, ".pc4"}, if_id_pc4, pc4);
      checkOutput({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
      checkOutput({tag, ".pc"}, pc, pcExp);
   endtask

   initial begin
      reset = 1'b0; stall = 1'b1; redirect = 1'b0; redirect_pc = '0;
      load_we = 1'b0; load_addr = '0; load_data = '0;
      stall8 = 1'b1; redirect8 = 1'b0; redirect_pc8 = '0;
      #12;
      checkIfId("reset", 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("reset.fault", 32'(fault), 32'h0);
      reset = 1'b1;

      // Load program while stalled
      load_we = 1'b1;
      load_addr = 6'd0; load_data = 32'h20080005; applyStimulus();
      load_addr = 6'd1; load_data = 32'h20090003; applyStimulus();
      load_addr = 6'd2; load_data = 32'h01095020; applyStimulus();
      load_addr = 6'd4; load_data = 32'hAAAA0004; applyStimulus();
      load_we = 1'b0;
      checkIfId("loadStall", 32'h0, 32'h0, 1'b0, 32'h0);

      stall = 1'b0;
      applyStimulus(); checkIfId("fetch0", 32'h20080005, 32'h4, 1'b1, 32'h4);
      applyStimulus(); checkIfId("fetch1", 32'h20090003, 32'h8, 1'b1, 32'h8);

      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(); checkIfId("stallHold", 32'h20090003, 32'h8, 1'b1, 32'h8);
      end
      stall = 1'b0;
      applyStimulus(); checkIfId("fetch2", 32'h01095020, 32'hC, 1'b1, 32'hC);

      // Redirect wins over a simultaneous stall
      redirect = 1'b1; redirect_pc = 32'h10; stall = 1'b1;
      applyStimulus(); checkIfId("redirBubble", 32'h0, 32'h0, 1'b0, 32'h10);
      checkOutput("redirAligned.fault", 32'(fault), 32'h0);
      redirect = 1'b0; stall = 1'b0;
      applyStimulus(); checkIfId("redirTarget", 32'hAAAA0004, 32'h14, 1'b1, 32'h14);

      // Same-edge load and fetch of index 5 returns the old word
      load_we = 1'b1; load_addr = 6'd5; load_data = 32'hBBBB0005;
      applyStimulus(); checkIfId("rbwOld", 32'h0, 32'h18, 1'b1, 32'h18);
      load_we = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h14;
      applyStimulus();
      redirect = 1'b0;
      applyStimulus(); checkIfId("rbwNew", 32'hBBBB0005, 32'h18, 1'b1, 32'h18);

      // Misaligned redirect target
      redirect = 1'b1; redirect_pc = 32'h0E;
      applyStimulus();
      checkOutput("misalign.pc", pc, 32'hC);
      checkOutput("misalign.fault", 32'(fault), 32'h1);
      redirect = 1'b0;
      applyStimulus(); applyStimulus();
      checkOutput("misalignSticky.fault", 32'(fault), 32'h1);
      checkOutput("misalignSticky.pc", pc, 32'h14);

      // Asynchronous reset between edges, with a redirect pending
      redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
      #2 reset = 1'b0;
      #1;
      checkIfId("asyncReset", 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("asyncReset.fault", 32'(fault), 32'h0);
      applyStimulus();
      checkOutput("resetHeld.pc", pc, 32'h0);
      redirect = 1'b0; stall = 1'b0;
      #2 reset = 1'b1;
      applyStimulus(); checkIfId("storeCleared", 32'h0, 32'h4, 1'b1, 32'h4);

      // Out-of-range fetch, with index 0 loaded so aliasing would be visible
      redirect = 1'b1; redirect_pc = 32'hFC;
      load_we = 1'b1; load_addr = 6'd0; load_data = 32'h12345678;
      stall8 = 1'b0; redirect8 = 1'b1; redirect_pc8 = 8'hFC;
      applyStimulus();
      checkOutput("oor.redirPc", pc, 32'hFC);
      checkOutput("w8.redirPc", 32'(pc8), 32'hFC);
      redirect = 1'b0; load_we = 1'b0; redirect8 = 1'b0;
      applyStimulus();
      checkIfId("lastWord", 32'h0, 32'h100, 1'b1, 32'h100);
      checkOutput("lastWord.fault", 32'(fault), 32'h0);
      checkOutput("w8.wrapPc", 32'(pc8), 32'h00);
      checkOutput("w8.wrapPc4", 32'(if_id_pc4_8), 32'h00);
      checkOutput("w8.valid", 32'(if_id_valid8), 32'h1);
      checkOutput("w8.fault", 32'(fault8), 32'h0);
      applyStimulus();
      checkIfId("outOfRange", 32'h0, 32'h104, 1'b1, 32'h104);
      checkOutput("outOfRange.fault", 32'(fault), 32'h1);
      applyStimulus();
      checkOutput("oorSticky.fault", 32'(fault), 32'h1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/if_stage_pipelined.md
# if_stage_pipelined

Parametrised instruction-fetch stage for the pipelined MIPS core: program counter, next-PC selection, a word-addressed instruction store with a load port, and the IF/ID pipeline register. It adds what the plain fetch wrapper lacks: an owned PC register, stall and redirect (branch/jump) handling, bubble insertion, and an out-of-range/misalignment fault flag. It sits between the hazard/branch logic (stall, redirect sources) and the decode stage (IF/ID consumer).

## Interface
- ADDR_W, 32, PC width in bits (≥ 8)
- DATA_W, 32, instruction width in bits
- DEPTH, 64, instruction store depth in words (power of two, ≥ 4)
- RESET_PC, 0, PC value after reset (word-aligned)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- stall  input  1  hold PC and IF/ID register
- redirect  input  1  take redirect_pc as next PC; squash IF/ID
- redirect_pc  input  ADDR_W  branch/jump target
- load_we  input  1  write enable for instruction store
- load_addr  input  $clog2(DEPTH)  word index to write
- load_data  input  DATA_W  word to write
- pc  output  ADDR_W  current fetch PC
- if_id_instr  output  DATA_W  registered instruction
- if_id_pc4  output  ADDR_W  registered fetch PC + 4
- if_id_valid  output  1  IF/ID holds a real instruction
- fault  output  1  sticky fetch/redirect address fault

## Operation
- Reset (reset=0, async): pc=RESET_PC; if_id_instr=0; if_id_pc4=0; if_id_valid=0; fault=0; every store word cleared to 0.
- Word index = pc[$clog2(DEPTH)+1:2]; pc in range when pc>>2 < DEPTH. Out-of-range fetch returns 0 (NOP).
- Per rising edge, priority redirect > stall > normal:
  - redirect=1: pc←{redirect_pc[ADDR_W-1:2],2'b00}; if_id_instr←0, if_id_pc4←0, if_id_valid←0. Applies even if stall=1.
  - stall=1, redirect=0: pc and all if_id_* hold.
  - normal: if_id_instr←store[index], if_id_pc4←pc+4, if_id_valid←1, pc←pc+4.
- pc+4 is modulo 2^ADDR_W (0xFFFFFFFC → 0x00000000 for ADDR_W=32).
- fault set (and held until reset) when: redirect=1 with redirect_pc[1:0]≠0, or a normal (non-stalled, non-redirected) fetch with pc out of range.
- Load port: load_we=1 writes store[load_addr]←load_data at the edge, independent of stall/redirect. Same-edge fetch of the same index captures the old word (read-before-write).

## Timing
- Fetch latency 1 cycle: word at pc appears on if_id_instr after the edge that advances pc.
- First edge after reset release: if_id_instr=store[RESET_PC>>2], if_id_valid=1, pc=RESET_PC+4.
- Redirect at edge N: if_id_valid=0 after N (one bubble); target word in IF/ID after N+1.
- Stall held K edges: outputs frozen K cycles, then resume from held pc with no skipped or duplicated word.
- Reset asserted mid-operation: all outputs to reset values immediately, without waiting for clk; a pending stall/redirect is discarded.
- pc is a register output; no combinational path from inputs to any output.

## Test plan
- Reset then load words 0x20080005, 0x20090003, 0x01095020 at indices 0..2, release stall: IF/ID shows them in order with if_id_pc4 = 4, 8, 12 and valid=1.
- Stall asserted for 3 cycles after second fetch: pc stays 8, if_id_instr stays 0x20090003; after release next IF/ID is 0x01095020.
- Redirect to 0x10 with stall=1 simultaneously: next edge pc=0x10, if_id_valid=0; following edge if_id_instr=store[4], if_id_pc4=0x14.
- Redirect to 0x0E: pc=0x0C, fault=1, fault remains 1 after further normal fetches until reset.
- DEPTH=64, run pc to 0x100: if_id_instr=0, fault=1; ADDR_W=8 run from 0xFC: pc wraps to 0x00.
- Drop reset mid-stream (between edges): pc=RESET_PC, if_id_valid=0, fault=0, store reads 0 before next edge.
